// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the ALU, issue-FSM state encoding and opcode legality helper.
package alu_pkg;
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB = 4'b0001;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    RESP    = ST_RESP
  } state_t;
  function automatic logic op_legal(input logic [3:0] op);
    return op == ALU_OP_ADD || op == ALU_OP_SUB;
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU and response signals of the issue stage; master drives commands, slave is the issue block.
interface alu_issue_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready, alu_result,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready, alu_result,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous command FIFO with full/empty flags and power-of-two wrapping pointers.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: buffers ALU commands, issues them one at a time to a registered ALU and returns in-order responses;
// illegal opcodes bypass the ALU and complete with the error flag set.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave io_bus
);
  localparam int DW = 2*WIDTH+4;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_res, w_alu_a, w_alu_b, w_res;
  logic [3:0]       r_alu_op, w_alu_op;
  logic             r_valid, r_err, w_valid, w_err;
  logic             w_pop, w_full, w_empty;
  logic [DW-1:0]    w_head;
  logic [WIDTH-1:0] w_ha, w_hb;
  logic [3:0]       w_hop;
  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (io_bus.in_valid),
    .i_data  ({io_bus.in_a, io_bus.in_b, io_bus.in_op}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign {w_ha, w_hb, w_hop} = w_head;
  assign io_bus.in_ready   = !w_full;
  assign io_bus.alu_a      = r_alu_a;
  assign io_bus.alu_b      = r_alu_b;
  assign io_bus.alu_op     = r_alu_op;
  assign io_bus.out_valid  = r_valid;
  assign io_bus.out_result = r_res;
  assign io_bus.out_err    = r_err;
  // IDLE and an acknowledged RESP share the dispatch path, so illegal commands stream at one per cycle
  always_comb begin
    w_state  = r_state;
    w_alu_a  = r_alu_a;
    w_alu_b  = r_alu_b;
    w_alu_op = r_alu_op;
    w_res    = r_res;
    w_err    = r_err;
    w_valid  = r_valid;
    w_pop    = 1'b0;
    case (r_state)
      IDLE, RESP: if (r_state == IDLE || io_bus.out_ready) begin
        w_valid = 1'b0;
        w_state = IDLE;
        if (!w_empty) begin
          w_pop = 1'b1;
          if (op_legal(w_hop)) begin
            w_alu_a  = w_ha;
            w_alu_b  = w_hb;
            w_alu_op = w_hop;
            w_state  = ISSUE;
          end else begin
            w_res   = '0;
            w_err   = 1'b1;
            w_valid = 1'b1;
            w_state = RESP;
          end
        end
      end
      ISSUE: w_state = CAPTURE;
      CAPTURE: begin
        w_res   = io_bus.alu_result;
        w_err   = 1'b0;
        w_valid = 1'b1;
        w_state = RESP;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= ALU_OP_ADD;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_alu_a  <= w_alu_a;
      r_alu_b  <= w_alu_b;
      r_alu_op <= w_alu_op;
      r_res    <= w_res;
      r_err    <= w_err;
      r_valid  <= w_valid;
    end
  end
endmodule
